// File: rtl/gameport_ctrl.sv
// gameport_ctrl: bus-side sequencer for the PC game port (0x200-0x207).
//  - Bus writes become one-cycle joy_write trigger pulses.
//  - Bus reads return joy_readdata one cycle later.
//  - An IDLE/TRIG/WAIT/MEASURE machine tracks each one-shot measurement
//    and aborts it after TIMEOUT cycles in MEASURE.
//  - clk_grav is the Gravis GamePad Pro serial clock, running only in mode 2.
// Optional build macro GAMEPORT_AXIS_CAPTURE_EN adds per-axis cycle
// counters on outputs axis_time_0..axis_time_3.
module gameport_ctrl #(
  parameter int unsigned GRAV_HALF = 2262,
  parameter int unsigned TIMEOUT   = 262144
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_cs,
  input  logic       io_read,
  input  logic       io_write,
  output logic [7:0] io_readdata,
  input  logic [1:0] mode,
  input  logic [7:0] joy_readdata,
  output logic       joy_write,
  output logic       clk_grav,
  output logic       busy,
`ifdef GAMEPORT_AXIS_CAPTURE_EN
  output logic [15:0] axis_time_0,
  output logic [15:0] axis_time_1,
  output logic [15:0] axis_time_2,
  output logic [15:0] axis_time_3,
`endif
  output logic       timeout_flag
);

  // The timeout counter must hold TIMEOUT-1 and is never narrower than 18 bits.
  localparam int unsigned TW = ($clog2(TIMEOUT) > 18) ? $clog2(TIMEOUT) : 18;
  localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT - 1);
  localparam logic [15:0]   GRAV_LAST = 16'(GRAV_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRIG    = 2'd1,
    S_WAIT    = 2'd2,
    S_MEASURE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tflag_q, tflag_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [15:0]   gcnt_q, gcnt_d;
  logic          grav_q, grav_d;
  logic          timeout_hit;

  logic wr_hit, rd_hit;
  assign wr_hit = io_cs & io_write;
  assign rd_hit = io_cs & io_read;

  // State register (synchronous active-low reset).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: a valid write always (re)starts at TRIG.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal
    // unassigned, which would infer a latch.
    state_d     = state_q;
    timeout_hit = 1'b0;
    if (wr_hit) begin
      state_d = S_TRIG;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_TRIG:  state_d = S_WAIT;
        S_WAIT:  state_d = S_MEASURE;
        S_MEASURE: begin
          if (joy_readdata[3:0] == 4'd0) begin
            state_d = S_IDLE;
          end else if (tcnt_q == T_LAST) begin
            state_d     = S_IDLE;
            timeout_hit = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the registered state (Moore outputs, glitch-free).
  always_comb begin
    joy_write = (state_q == S_TRIG);
    busy      = (state_q != S_IDLE);
  end

  // Timeout counter, sticky timeout flag and read-data holding register.
  always_comb begin
    tcnt_d  = tcnt_q;
    tflag_d = tflag_q;
    rdata_d = rdata_q;
    if (state_q == S_TRIG) begin
      tcnt_d = '0;
    end else if (state_q == S_MEASURE && tcnt_q != T_LAST) begin
      tcnt_d = tcnt_q + 1'b1;
    end
    if (wr_hit)           tflag_d = 1'b0;
    else if (timeout_hit) tflag_d = 1'b1;
    // A read in the same cycle as a write captures pre-trigger status.
    if (rd_hit) rdata_d = joy_readdata;
  end

  // Measurement-side registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt_q  <= '0;
      tflag_q <= 1'b0;
      rdata_q <= 8'hFF;
    end else begin
      tcnt_q  <= tcnt_d;
      tflag_q <= tflag_d;
      rdata_q <= rdata_d;
    end
  end

  assign io_readdata  = rdata_q;
  assign timeout_flag = tflag_q;

  // Gravis half-period divider: runs only in mode 2, otherwise parked at 0.
  always_comb begin
    gcnt_d = 16'd0;
    grav_d = 1'b0;
    if (mode == 2'd2) begin
      if (gcnt_q == GRAV_LAST) begin
        gcnt_d = 16'd0;
        grav_d = ~grav_q;
      end else begin
        gcnt_d = gcnt_q + 16'd1;
        grav_d = grav_q;
      end
    end
  end

  // Gravis clock registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gcnt_q <= 16'd0;
      grav_q <= 1'b0;
    end else begin
      gcnt_q <= gcnt_d;
      grav_q <= grav_d;
    end
  end

  assign clk_grav = grav_q;

`ifdef GAMEPORT_AXIS_CAPTURE_EN
  logic [15:0] axis_q [4];
  logic [15:0] axis_d [4];
  logic [3:0]  run_q, run_d;

  // Per-axis timers: cleared at TRIG, count in MEASURE while the axis bit is
  // high, frozen from the first cycle it reads low, saturating at 16'hFFFF.
  always_comb begin
    run_d = run_q;
    for (int i = 0; i < 4; i++) begin
      axis_d[i] = axis_q[i];
      if (state_q == S_TRIG) begin
        axis_d[i] = 16'd0;
        run_d[i]  = 1'b1;
      end else if (state_q == S_MEASURE && run_q[i]) begin
        if (!joy_readdata[i])          run_d[i]  = 1'b0;
        else if (axis_q[i] != 16'hFFFF) axis_d[i] = axis_q[i] + 16'd1;
      end
    end
  end

  // Axis timer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q <= 4'd0;
      for (int i = 0; i < 4; i++) axis_q[i] <= 16'd0;
    end else begin
      run_q <= run_d;
      for (int i = 0; i < 4; i++) axis_q[i] <= axis_d[i];
    end
  end

  assign axis_time_0 = axis_q[0];
  assign axis_time_1 = axis_q[1];
  assign axis_time_2 = axis_q[2];
  assign axis_time_3 = axis_q[3];
`endif

endmodule

// File: tb/tb_gameport_ctrl.sv
// Self-checking bench for gameport_ctrl (default build, small parameters).
// A cycle-level reference model built from elapsed-cycle arithmetic is
// compared against the DUT every cycle; directed literal checks pin it.
module tb_gameport_ctrl;
  localparam int TO = 100;
  localparam int GH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       io_cs = 1'b0, io_read = 1'b0, io_write = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] joy = 8'hFF;
  logic [7:0] io_readdata;
  logic       joy_write, clk_grav, busy, timeout_flag;

  int n_vec = 0;
  int n_err = 0;

  gameport_ctrl #(.GRAV_HALF(GH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .io_cs(io_cs), .io_read(io_read),
    .io_write(io_write), .io_readdata(io_readdata), .mode(mode),
    .joy_readdata(joy), .joy_write(joy_write), .clk_grav(clk_grav),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_age = cycles since the trigger write (-1 when idle);
  // the measurement lasts TRIG+WAIT+up to TO cycles. Gravis level follows
  // from how many consecutive edges have seen mode 2.
  int         m_age = -1;
  bit         m_tflag = 1'b0;
  logic [7:0] m_rd = 8'hFF;
  int         m_streak = 0;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_age    <= -1;
      m_tflag  <= 1'b0;
      m_rd     <= 8'hFF;
      m_streak <= 0;
      m_valid  <= 1'b1;
    end else begin
      if (io_cs && io_read) m_rd <= joy;
      m_streak <= (mode == 2'd2) ? m_streak + 1 : 0;
      if (io_cs && io_write) begin
        m_age   <= 0;
        m_tflag <= 1'b0;
      end else if (m_age >= 0) begin
        if (m_age >= 2 && joy[3:0] == 4'd0) begin
          m_age <= -1;
        end else if (m_age == TO + 1) begin
          m_age   <= -1;
          m_tflag <= 1'b1;
        end else begin
          m_age <= m_age + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("m_readdata", {24'd0, io_readdata}, {24'd0, m_rd});
      check("m_busy", {31'd0, busy}, {31'd0, (m_age >= 0)});
      check("m_joy_write", {31'd0, joy_write}, {31'd0, (m_age == 0)});
      check("m_timeout_flag", {31'd0, timeout_flag}, {31'd0, m_tflag});
      check("m_clk_grav", {31'd0, clk_grav}, {31'd0, (((m_streak / GH) % 2) == 1)});
    end
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic do_write();
    io_cs = 1'b1; io_write = 1'b1;
    @(negedge clk);
    io_cs = 1'b0; io_write = 1'b0;
  endtask

  task automatic do_read();
    io_cs = 1'b1; io_read = 1'b1;
    @(negedge clk);
    io_cs = 1'b0; io_read = 1'b0;
  endtask

  // Counts busy cycles from the current one, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  logic g [0:20];
  int   n;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check("rst_readdata", {24'd0, io_readdata}, 32'hFF);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_joy_write", {31'd0, joy_write}, 32'd0);
    check("rst_clk_grav", {31'd0, clk_grav}, 32'd0);
    check("rst_tflag", {31'd0, timeout_flag}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Trigger, read during measurement, release on zero axis bits
    joy = 8'hFF;
    do_write();
    check("trig_jw", {31'd0, joy_write}, 32'd1);
    check("trig_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("trig_jw_one_cycle", {31'd0, joy_write}, 32'd0);
    repeat (5) @(negedge clk);
    do_read();
    check("read_ff", {24'd0, io_readdata}, 32'hFF);
    repeat (20) @(negedge clk);
    check("still_busy", {31'd0, busy}, 32'd1);
    joy = 8'hF0;
    @(negedge clk);
    check("release_busy", {31'd0, busy}, 32'd0);
    check("release_tflag", {31'd0, timeout_flag}, 32'd0);

    // Plain read in IDLE
    joy = 8'h3C;
    do_read();
    check("read_3c", {24'd0, io_readdata}, 32'h3C);

    // Strobes without chip select are ignored
    joy = 8'h55;
    io_read = 1'b1;
    @(negedge clk);
    io_read = 1'b0;
    check("nocs_read", {24'd0, io_readdata}, 32'h3C);
    io_write = 1'b1;
    @(negedge clk);
    io_write = 1'b0;
    check("nocs_jw", {31'd0, joy_write}, 32'd0);
    check("nocs_busy", {31'd0, busy}, 32'd0);

    // Simultaneous read+write: read sees pre-trigger data; shortest measurement
    joy = 8'h81;
    io_cs = 1'b1; io_read = 1'b1; io_write = 1'b1;
    @(negedge clk);
    io_cs = 1'b0; io_read = 1'b0; io_write = 1'b0;
    joy = 8'h40;
    check("rw_read", {24'd0, io_readdata}, 32'h81);
    check("rw_jw", {31'd0, joy_write}, 32'd1);
    wait_idle(n);
    check("min_measure_len", n, 32'd3);

    // Timeout with axis 0 stuck high
    joy = 8'h01;
    do_write();
    wait_idle(n);
    check("timeout_len", n, TO + 2);
    check("timeout_flag_set", {31'd0, timeout_flag}, 32'd1);
    do_write();
    check("timeout_flag_clr", {31'd0, timeout_flag}, 32'd0);

    // Retrigger 50 cycles into MEASURE restarts the timeout
    repeat (52) @(negedge clk);
    check("retrig_pre_jw", {31'd0, joy_write}, 32'd0);
    do_write();
    check("retrig_jw", {31'd0, joy_write}, 32'd1);
    wait_idle(n);
    check("retrig_len", n, TO + 2);
    check("retrig_tflag", {31'd0, timeout_flag}, 32'd1);

    // Gravis clock from entry into mode 2
    joy = 8'hF0;
    mode = 2'd2;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      g[k] = clk_grav;
    end
    check("grav_c3_low", {31'd0, g[3]}, 32'd0);
    check("grav_c4_rise", {31'd0, g[4]}, 32'd1);
    check("grav_c7_high", {31'd0, g[7]}, 32'd1);
    check("grav_c8_fall", {31'd0, g[8]}, 32'd0);
    check("grav_c12_rise", {31'd0, g[12]}, 32'd1);
    check("grav_c16_fall", {31'd0, g[16]}, 32'd0);
    do_write();
    repeat (7) @(negedge clk);
    n = 0;
    while (!clk_grav && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("grav_high_seen", {31'd0, clk_grav}, 32'd1);
    mode = 2'd0;
    @(negedge clk);
    check("grav_drop", {31'd0, clk_grav}, 32'd0);
    repeat (10) @(negedge clk);
    mode = 2'd3;
    repeat (10) @(negedge clk);
    check("grav_mode3_low", {31'd0, clk_grav}, 32'd0);

    // Reset mid-measurement with clk_grav high
    mode = 2'd2;
    joy = 8'h7E;
    do_read();
    check("read_7e", {24'd0, io_readdata}, 32'h7E);
    do_write();
    repeat (3) @(negedge clk);
    n = 0;
    while (!clk_grav && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_grav", {31'd0, clk_grav}, 32'd1);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_readdata", {24'd0, io_readdata}, 32'hFF);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_grav", {31'd0, clk_grav}, 32'd0);
    check("mid_rst_jw", {31'd0, joy_write}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
